// File: rtl/spl_rd_arbiter_4x1_pkg.sv
// Shared definitions for the 4-client read arbiter: client count, default
// sizing and the round-robin pick helper.
package spl_rd_arbiter_4x1_pkg;

    localparam int NUM_CLIENTS    = 4;
    localparam int CLIENT_W       = 2;
    localparam int DEPTH_DEFAULT  = 16;
    localparam int REQ_W_DEFAULT  = 80;
    localparam int RESP_W_DEFAULT = 528;

    typedef logic [CLIENT_W-1:0] client_t;

    // First valid client found searching upward from ptr, wrapping mod 4.
    // Returns ptr when nothing is valid; callers qualify with any-valid.
    function automatic client_t rr_pick(input logic [NUM_CLIENTS-1:0] valid,
                                        input client_t ptr);
        client_t idx;
        rr_pick = ptr;
        // Walk from the farthest offset down so the nearest valid wins last.
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            idx = ptr + client_t'(i);
            if (valid[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/spl_rd_arbiter_4x1_order.sv
// Order FIFO: remembers which client issued each outstanding read so that
// in-order memory responses can be routed back. Pointers carry one extra
// wrap bit to tell full from empty; storage is not reset.
module spl_order_fifo
    import spl_rd_arbiter_4x1_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  client_t                  din,
    input  logic                     pop,
    output client_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    client_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push while full is dropped even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; wraps naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spl_rd_arbiter_4x1.sv
// Four-client read arbiter in front of a single in-order memory read port.
// Requests are granted round-robin with zero added latency; a stalled grant
// is locked so the presented request stays stable. Responses are steered by
// the head of the order FIFO.
module spl_rd_arbiter_4x1
    import spl_rd_arbiter_4x1_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int REQ_W  = REQ_W_DEFAULT,
    parameter int RESP_W = RESP_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cl_rd_req_0_valid,
    output logic                    cl_rd_req_0_ready,
    input  logic [REQ_W-1:0]        cl_rd_req_0_bits,
    input  logic                    cl_rd_req_1_valid,
    output logic                    cl_rd_req_1_ready,
    input  logic [REQ_W-1:0]        cl_rd_req_1_bits,
    input  logic                    cl_rd_req_2_valid,
    output logic                    cl_rd_req_2_ready,
    input  logic [REQ_W-1:0]        cl_rd_req_2_bits,
    input  logic                    cl_rd_req_3_valid,
    output logic                    cl_rd_req_3_ready,
    input  logic [REQ_W-1:0]        cl_rd_req_3_bits,

    output logic                    cl_rd_resp_0_valid,
    input  logic                    cl_rd_resp_0_ready,
    output logic [RESP_W-1:0]       cl_rd_resp_0_bits,
    output logic                    cl_rd_resp_1_valid,
    input  logic                    cl_rd_resp_1_ready,
    output logic [RESP_W-1:0]       cl_rd_resp_1_bits,
    output logic                    cl_rd_resp_2_valid,
    input  logic                    cl_rd_resp_2_ready,
    output logic [RESP_W-1:0]       cl_rd_resp_2_bits,
    output logic                    cl_rd_resp_3_valid,
    input  logic                    cl_rd_resp_3_ready,
    output logic [RESP_W-1:0]       cl_rd_resp_3_bits,

    output logic                    spl_rd_req_valid,
    input  logic                    spl_rd_req_ready,
    output logic [REQ_W-1:0]        spl_rd_req_bits,

    input  logic                    spl_rd_resp_valid,
    output logic                    spl_rd_resp_ready,
    input  logic [RESP_W-1:0]       spl_rd_resp_bits,

    output logic [$clog2(DEPTH):0]  outstanding
);

    logic [NUM_CLIENTS-1:0] req_valid_vec;
    logic [NUM_CLIENTS-1:0] resp_ready_vec;
    client_t                rr_ptr;
    client_t                lock_gnt;
    logic                   lock_held;
    client_t                gnt;
    client_t                head;
    logic                   full;
    logic                   empty;
    logic                   req_fire;
    logic                   resp_fire;

    assign req_valid_vec  = {cl_rd_req_3_valid, cl_rd_req_2_valid,
                             cl_rd_req_1_valid, cl_rd_req_0_valid};
    assign resp_ready_vec = {cl_rd_resp_3_ready, cl_rd_resp_2_ready,
                             cl_rd_resp_1_ready, cl_rd_resp_0_ready};

    // A held lock overrides fresh arbitration so the stalled request is stable.
    assign gnt = lock_held ? lock_gnt : rr_pick(req_valid_vec, rr_ptr);

    assign spl_rd_req_valid = rst && ((|req_valid_vec) || lock_held) && !full;
    assign req_fire         = spl_rd_req_valid && spl_rd_req_ready;

    assign cl_rd_req_0_ready = req_fire && (gnt == client_t'(0));
    assign cl_rd_req_1_ready = req_fire && (gnt == client_t'(1));
    assign cl_rd_req_2_ready = req_fire && (gnt == client_t'(2));
    assign cl_rd_req_3_ready = req_fire && (gnt == client_t'(3));

    // Request payload mux from the granted client.
    always_comb begin
        spl_rd_req_bits = cl_rd_req_0_bits;
        case (gnt)
            2'd1:    spl_rd_req_bits = cl_rd_req_1_bits;
            2'd2:    spl_rd_req_bits = cl_rd_req_2_bits;
            2'd3:    spl_rd_req_bits = cl_rd_req_3_bits;
            default: spl_rd_req_bits = cl_rd_req_0_bits;
        endcase
    end

    // Round-robin pointer and grant lock; the lock drops on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            lock_held <= 1'b0;
            lock_gnt  <= '0;
        end else if (req_fire) begin
            rr_ptr    <= gnt + client_t'(1);
            lock_held <= 1'b0;
        end else if (spl_rd_req_valid) begin
            lock_held <= 1'b1;
            lock_gnt  <= gnt;
        end
    end

    // Responses go to the client at the FIFO head; stray ones are never taken.
    assign spl_rd_resp_ready = rst && !empty && resp_ready_vec[head];
    assign resp_fire         = spl_rd_resp_valid && spl_rd_resp_ready;

    assign cl_rd_resp_0_valid = rst && spl_rd_resp_valid && !empty && (head == client_t'(0));
    assign cl_rd_resp_1_valid = rst && spl_rd_resp_valid && !empty && (head == client_t'(1));
    assign cl_rd_resp_2_valid = rst && spl_rd_resp_valid && !empty && (head == client_t'(2));
    assign cl_rd_resp_3_valid = rst && spl_rd_resp_valid && !empty && (head == client_t'(3));

    assign cl_rd_resp_0_bits = spl_rd_resp_bits;
    assign cl_rd_resp_1_bits = spl_rd_resp_bits;
    assign cl_rd_resp_2_bits = spl_rd_resp_bits;
    assign cl_rd_resp_3_bits = spl_rd_resp_bits;

    spl_order_fifo #(
        .DEPTH (DEPTH)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .din   (gnt),
        .pop   (resp_fire),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

endmodule

// File: tb/tb_spl_rd_arbiter_4x1.sv
module tb_spl_rd_arbiter_4x1;

    localparam int DEPTH  = 16;
    localparam int REQ_W  = 80;
    localparam int RESP_W = 528;

    logic               clk;
    logic               rst;
    logic [3:0]         req_v;
    logic [3:0]         req_rdy;
    logic [REQ_W-1:0]   req_b [4];
    logic [3:0]         resp_v;
    logic [3:0]         resp_rdy;
    logic [RESP_W-1:0]  resp_b [4];
    logic               spl_req_valid;
    logic               spl_req_ready;
    logic [REQ_W-1:0]   spl_req_bits;
    logic               spl_resp_valid;
    logic               spl_resp_ready;
    logic [RESP_W-1:0]  spl_resp_bits;
    logic [4:0]         outstanding;

    int n_checks;
    int n_pass;

    spl_rd_arbiter_4x1 #(
        .DEPTH  (DEPTH),
        .REQ_W  (REQ_W),
        .RESP_W (RESP_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cl_rd_req_0_valid  (req_v[0]),
        .cl_rd_req_0_ready  (req_rdy[0]),
        .cl_rd_req_0_bits   (req_b[0]),
        .cl_rd_req_1_valid  (req_v[1]),
        .cl_rd_req_1_ready  (req_rdy[1]),
        .cl_rd_req_1_bits   (req_b[1]),
        .cl_rd_req_2_valid  (req_v[2]),
        .cl_rd_req_2_ready  (req_rdy[2]),
        .cl_rd_req_2_bits   (req_b[2]),
        .cl_rd_req_3_valid  (req_v[3]),
        .cl_rd_req_3_ready  (req_rdy[3]),
        .cl_rd_req_3_bits   (req_b[3]),
        .cl_rd_resp_0_valid (resp_v[0]),
        .cl_rd_resp_0_ready (resp_rdy[0]),
        .cl_rd_resp_0_bits  (resp_b[0]),
        .cl_rd_resp_1_valid (resp_v[1]),
        .cl_rd_resp_1_ready (resp_rdy[1]),
        .cl_rd_resp_1_bits  (resp_b[1]),
        .cl_rd_resp_2_valid (resp_v[2]),
        .cl_rd_resp_2_ready (resp_rdy[2]),
        .cl_rd_resp_2_bits  (resp_b[2]),
        .cl_rd_resp_3_valid (resp_v[3]),
        .cl_rd_resp_3_ready (resp_rdy[3]),
        .cl_rd_resp_3_bits  (resp_b[3]),
        .spl_rd_req_valid   (spl_req_valid),
        .spl_rd_req_ready   (spl_req_ready),
        .spl_rd_req_bits    (spl_req_bits),
        .spl_rd_resp_valid  (spl_resp_valid),
        .spl_rd_resp_ready  (spl_resp_ready),
        .spl_rd_resp_bits   (spl_resp_bits),
        .outstanding        (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance past a rising edge; inputs change here, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst            = 1'b0;
        req_v          = 4'b0000;
        resp_rdy       = 4'b1111;
        req_b[0]       = 80'h100;
        req_b[1]       = 80'h101;
        req_b[2]       = 80'hABC;
        req_b[3]       = 80'h103;
        spl_req_ready  = 1'b0;
        spl_resp_valid = 1'b0;
        spl_resp_bits  = '0;

        // Reset state
        #12;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_req_valid", 64'(spl_req_valid), 64'd0);
        chk("rst_resp_ready", 64'(spl_resp_ready), 64'd0);
        chk("rst_cl_ready", 64'(req_rdy), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // All four clients valid: grants rotate 0,1,2,3,0,1,2,3
        req_v = 4'b1111;
        spl_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_grant", 64'(req_rdy), 64'(4'b0001 << (i % 4)));
            chk("rr_bits", 64'(spl_req_bits), 64'(req_b[i % 4]));
            tick();
        end
        req_v = 4'b0000;
        #1;
        chk("rr_outstanding", 64'(outstanding), 64'd8);
        spl_resp_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            spl_resp_bits = RESP_W'(16'h500 + i);
            #1;
            chk("rr_resp_route", 64'(resp_v), 64'(4'b0001 << (i % 4)));
            tick();
        end
        spl_resp_valid = 1'b0;
        #1;
        chk("rr_drained", 64'(outstanding), 64'd0);

        // Stalled grant to client 2 stays locked when client 0 joins
        tick();
        req_v = 4'b0100;
        spl_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", 64'(spl_req_valid), 64'd1);
            chk("stall_bits", 64'(spl_req_bits), 64'hABC);
            tick();
        end
        req_v = 4'b0101;
        #1;
        chk("lock_bits", 64'(spl_req_bits), 64'hABC);
        chk("lock_no_ready", 64'(req_rdy), 64'd0);
        tick();
        #1;
        chk("lock_bits_2", 64'(spl_req_bits), 64'hABC);
        spl_req_ready = 1'b1;
        #1;
        chk("lock_handshake", 64'(req_rdy), 64'b0100);
        chk("lock_hs_bits", 64'(spl_req_bits), 64'hABC);
        tick();
        req_v = 4'b0001;
        #1;
        chk("after_lock_grant", 64'(req_rdy), 64'b0001);
        tick();
        req_v = 4'b0000;
        #1;
        chk("lock_outstanding", 64'(outstanding), 64'd2);
        spl_resp_valid = 1'b1;
        #1;
        chk("lock_resp0", 64'(resp_v), 64'b0100);
        tick();
        #1;
        chk("lock_resp1", 64'(resp_v), 64'b0001);
        tick();
        spl_resp_valid = 1'b0;

        // Requests from 3,1,3; responses R0,R1,R2 routed in order
        req_v = 4'b1000;
        #1;
        chk("ord_req3a", 64'(req_rdy), 64'b1000);
        tick();
        req_v = 4'b0010;
        #1;
        chk("ord_req1", 64'(req_rdy), 64'b0010);
        tick();
        req_v = 4'b1000;
        #1;
        chk("ord_req3b", 64'(req_rdy), 64'b1000);
        tick();
        req_v = 4'b0000;
        spl_resp_valid = 1'b1;
        spl_resp_bits = RESP_W'(8'hA0);
        #1;
        chk("ord_r0_valid", 64'(resp_v), 64'b1000);
        chk("ord_r0_bits", resp_b[3][63:0], 64'hA0);
        tick();
        spl_resp_bits = RESP_W'(8'hA1);
        #1;
        chk("ord_r1_valid", 64'(resp_v), 64'b0010);
        chk("ord_r1_bits", resp_b[1][63:0], 64'hA1);
        tick();
        spl_resp_bits = RESP_W'(8'hA2);
        #1;
        chk("ord_r2_valid", 64'(resp_v), 64'b1000);
        chk("ord_r2_bits", resp_b[3][63:0], 64'hA2);
        tick();

        // Stray response with nothing outstanding is not consumed
        #1;
        chk("stray_ready", 64'(spl_resp_ready), 64'd0);
        chk("stray_valid", 64'(resp_v), 64'd0);
        tick();
        spl_resp_valid = 1'b0;

        // Head client 1 back-pressures the response
        req_v = 4'b0010;
        tick();
        req_v = 4'b0000;
        spl_resp_valid = 1'b1;
        resp_rdy = 4'b1101;
        #1;
        chk("bp_valid", 64'(resp_v), 64'b0010);
        chk("bp_ready", 64'(spl_resp_ready), 64'd0);
        tick();
        #1;
        chk("bp_hold", 64'(outstanding), 64'd1);
        resp_rdy = 4'b1111;
        #1;
        chk("bp_release", 64'(spl_resp_ready), 64'd1);
        tick();
        spl_resp_valid = 1'b0;
        #1;
        chk("bp_popped", 64'(outstanding), 64'd0);

        // Fill the FIFO, then free one slot
        req_v = 4'b0001;
        for (int i = 0; i < 16; i++) tick();
        #1;
        chk("full_count", 64'(outstanding), 64'd16);
        chk("full_req_valid", 64'(spl_req_valid), 64'd0);
        chk("full_cl_ready", 64'(req_rdy), 64'd0);
        spl_resp_valid = 1'b1;
        #1;
        chk("full_pop_ready", 64'(spl_resp_ready), 64'd1);
        chk("full_no_push", 64'(spl_req_valid), 64'd0);
        tick();
        #1;
        chk("full_after_pop", 64'(outstanding), 64'd15);
        chk("refill_valid", 64'(spl_req_valid), 64'd1);
        chk("refill_ready", 64'(req_rdy), 64'b0001);
        tick();
        spl_resp_valid = 1'b0;
        #1;
        chk("push_pop_same", 64'(outstanding), 64'd15);
        tick();
        req_v = 4'b0000;
        #1;
        chk("refilled", 64'(outstanding), 64'd16);

        // Drain to 5, then reset mid-operation
        spl_resp_valid = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        #1;
        chk("pre_rst_count", 64'(outstanding), 64'd5);
        req_v = 4'b1111;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 64'(outstanding), 64'd0);
        chk("mid_rst_req_valid", 64'(spl_req_valid), 64'd0);
        chk("mid_rst_cl_ready", 64'(req_rdy), 64'd0);
        chk("mid_rst_resp_valid", 64'(resp_v), 64'd0);
        chk("mid_rst_resp_ready", 64'(spl_resp_ready), 64'd0);
        tick();
        rst = 1'b1;
        spl_resp_valid = 1'b0;
        #1;
        chk("post_rst_grant", 64'(req_rdy), 64'b0001);
        chk("post_rst_count", 64'(outstanding), 64'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
